// File: rtl/reg_file_mwb.sv
// 8 x 8-bit register file with a one-entry pending-write slot for late multiplier results.
// Reads forward from the slot so a result is visible the cycle after it is issued.
module reg_file_mwb #(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [WIDTH-1:0]  MULT_IN,
    input  logic [ADDR_W-1:0] MULT_ADDRESS,
    input  logic              MULT_WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic              PENDING,
    output logic [ADDR_W-1:0] PENDING_ADDRESS,
    output logic              WR_CONFLICT
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // The delays only shape the original behavioural model; this model updates at zero delay.
    if (READ_DELAY < 0 || WRITE_DELAY < 0) begin : g_bad_delay
    end

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [WIDTH-1:0]  slot_data_q, slot_data_d;
    logic              conflict_q, conflict_d;

    always_comb begin
        regs_d      = regs_q;
        state_d     = state_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        conflict_d  = WRITE & MULT_WRITE;

        if (state_q == ST_FULL) begin
            regs_d[slot_addr_q] = slot_data_q;
        end

        // Applied after the commit so the younger ALU result wins on an address clash.
        if (WRITE && !MULT_WRITE) begin
            regs_d[INADDRESS] = IN;
        end

        if (MULT_WRITE) begin
            state_d     = ST_FULL;
            slot_addr_d = MULT_ADDRESS;
            slot_data_d = MULT_IN;
        end else begin
            state_d     = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            state_q     <= ST_EMPTY;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            conflict_q  <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            state_q     <= state_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            conflict_q  <= conflict_d;
        end
    end

    assign OUT1 = (state_q == ST_FULL && slot_addr_q == OUT1ADDRESS) ? slot_data_q
                                                                       : regs_q[OUT1ADDRESS];
    assign OUT2 = (state_q == ST_FULL && slot_addr_q == OUT2ADDRESS) ? slot_data_q
                                                                       : regs_q[OUT2ADDRESS];

    assign PENDING         = state_q[0];
    assign PENDING_ADDRESS = slot_addr_q;
    assign WR_CONFLICT     = conflict_q;

endmodule

// File: tb/tb_reg_file_mwb.sv
// Bench for reg_file_mwb: directed write/read vectors, expected read-back pushed to a queue
// and checked by an independent monitor shortly after each read address is applied.
module tb_reg_file_mwb;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int EW     = 2 * WIDTH + 1 + ADDR_W + 1;

    logic              CLK;
    logic              RESET;
    logic [WIDTH-1:0]  IN;
    logic [ADDR_W-1:0] INADDRESS;
    logic              WRITE;
    logic [WIDTH-1:0]  MULT_IN;
    logic [ADDR_W-1:0] MULT_ADDRESS;
    logic              MULT_WRITE;
    logic [ADDR_W-1:0] OUT1ADDRESS;
    logic [ADDR_W-1:0] OUT2ADDRESS;
    logic [WIDTH-1:0]  OUT1;
    logic [WIDTH-1:0]  OUT2;
    logic              PENDING;
    logic [ADDR_W-1:0] PENDING_ADDRESS;
    logic              WR_CONFLICT;

    logic              chk_valid;
    logic [EW-1:0]     exp_q[$];
    int                n_cmp;
    int                n_bad;
    int                n_rd;
    bit                done;

    reg_file_mwb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .READ_DELAY(2), .WRITE_DELAY(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .MULT_IN(MULT_IN), .MULT_ADDRESS(MULT_ADDRESS), .MULT_WRITE(MULT_WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(OUT1), .OUT2(OUT2),
        .PENDING(PENDING), .PENDING_ADDRESS(PENDING_ADDRESS), .WR_CONFLICT(WR_CONFLICT)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // driver tasks: inputs change on negedge, state updates on the following posedge
    task automatic tick();
        @(negedge CLK);
        RESET      = 1'b0;
        WRITE      = 1'b0;
        MULT_WRITE = 1'b0;
        chk_valid  = 1'b0;
    endtask

    task automatic alu(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        WRITE = 1'b1; INADDRESS = a; IN = d;
    endtask

    task automatic mul(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        MULT_WRITE = 1'b1; MULT_ADDRESS = a; MULT_IN = d;
    endtask

    // Read request: expectation describes the state left by the previous posedge.
    task automatic rd(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                      input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                      input logic ep, input logic [ADDR_W-1:0] epa, input logic ec);
        OUT1ADDRESS = a1;
        OUT2ADDRESS = a2;
        chk_valid   = 1'b1;
        exp_q.push_back({e1, e2, ep, epa, ec});
    endtask

    // scoreboard monitor: samples 3 units after the read address changes
    initial begin
        logic [EW-1:0]     e;
        logic [WIDTH-1:0]  e1, e2;
        logic              ep, ec;
        logic [ADDR_W-1:0] epa;
        bit                ok;
        forever begin
            @(negedge CLK);
            #3;
            if (chk_valid) begin
                n_rd++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd%0d: read presented with no expectation queued", n_rd);
                end else begin
                    e = exp_q.pop_front();
                    {e1, e2, ep, epa, ec} = e;
                    ok = (OUT1 === e1) && (OUT2 === e2) && (PENDING === ep) &&
                         (WR_CONFLICT === ec) && (!ep || PENDING_ADDRESS === epa);
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL rd%0d: got out1=%h out2=%h pend=%b paddr=%0d conf=%b, want out1=%h out2=%h pend=%b paddr=%0d conf=%b",
                                 n_rd, OUT1, OUT2, PENDING, PENDING_ADDRESS, WR_CONFLICT,
                                 e1, e2, ep, epa, ec);
                    end
                end
            end
        end
    end

    // directed stimulus
    initial begin
        logic [WIDTH-1:0] tbl [8];
        tbl = '{8'h00, 8'h81, 8'h7F, 8'hFF, 8'h10, 8'hA5, 8'h3C, 8'hC3};
        n_cmp = 0; n_bad = 0; n_rd = 0; done = 1'b0;
        RESET = 1'b1; WRITE = 1'b0; MULT_WRITE = 1'b0; chk_valid = 1'b0;
        IN = '0; INADDRESS = '0; MULT_IN = '0; MULT_ADDRESS = '0;
        OUT1ADDRESS = '0; OUT2ADDRESS = '0;
        tick(); RESET = 1'b1;
        tick(); rd(0, 7, 8'h00, 8'h00, 1'b0, 0, 1'b0);

        // reset clears a written register
        alu(3, 8'h5A);
        tick(); RESET = 1'b1; rd(3, 3, 8'h5A, 8'h5A, 1'b0, 0, 1'b0);
        tick(); rd(3, 3, 8'h00, 8'h00, 1'b0, 0, 1'b0);

        // ALU writes on consecutive edges
        alu(1, 8'h11);
        tick(); alu(2, 8'hF0); rd(1, 2, 8'h11, 8'h00, 1'b0, 0, 1'b0);
        tick(); rd(1, 2, 8'h11, 8'hF0, 1'b0, 0, 1'b0);

        // multiplier result forwarded from the slot, then committed
        mul(4, 8'hC8);
        tick(); rd(4, 4, 8'hC8, 8'hC8, 1'b1, 4, 1'b0);
        tick(); rd(4, 1, 8'hC8, 8'h11, 1'b0, 0, 1'b0);

        // back-to-back multiplies
        mul(5, 8'h06);
        tick(); mul(6, 8'h0F); rd(5, 6, 8'h06, 8'h00, 1'b1, 5, 1'b0);
        tick(); rd(5, 6, 8'h06, 8'h0F, 1'b1, 6, 1'b0);
        tick(); rd(6, 5, 8'h0F, 8'h06, 1'b0, 0, 1'b0);

        // commit collides with ALU write to the same register
        mul(2, 8'h33);
        tick(); alu(2, 8'h44); rd(2, 2, 8'h33, 8'h33, 1'b1, 2, 1'b0);
        tick(); rd(2, 2, 8'h44, 8'h44, 1'b0, 0, 1'b0);
        tick(); rd(2, 4, 8'h44, 8'hC8, 1'b0, 0, 1'b0);

        // commit alongside an ALU write to a different register
        mul(1, 8'h77);
        tick(); alu(3, 8'h99); rd(1, 3, 8'h77, 8'h00, 1'b1, 1, 1'b0);
        tick(); rd(1, 3, 8'h77, 8'h99, 1'b0, 0, 1'b0);

        // simultaneous WRITE and MULT_WRITE: ALU write dropped
        alu(7, 8'hAA); mul(0, 8'h01);
        tick(); rd(7, 0, 8'h00, 8'h01, 1'b1, 0, 1'b1);
        tick(); rd(7, 0, 8'h00, 8'h01, 1'b0, 0, 1'b0);

        // reset while a multiplier result is pending
        RESET = 1'b1;
        tick(); mul(0, 8'h5C);
        tick(); RESET = 1'b1; rd(0, 0, 8'h5C, 8'h5C, 1'b1, 0, 1'b0);
        tick(); rd(0, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0);

        // reset clears a raised conflict flag
        alu(1, 8'h01); mul(2, 8'h02);
        tick(); RESET = 1'b1; rd(1, 2, 8'h00, 8'h02, 1'b1, 2, 1'b1);
        tick(); rd(1, 2, 8'h00, 8'h00, 1'b0, 0, 1'b0);

        // fill every register, then read independent pairs
        for (int i = 0; i < 8; i++) begin
            alu(i[ADDR_W-1:0], tbl[i]);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            rd(i[ADDR_W-1:0], 3'(7 - i), tbl[i], tbl[7 - i], 1'b0, 0, 1'b0);
            tick();
        end

        repeat (3) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // watchdog
    initial begin
        #50000;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog: run still active at %0t, want finished", $time);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

endmodule

// File: doc/reg_file_mwb.md
Name: reg_file_mwb

Overview:
- 8 x 8-bit register file for the single-cycle processor, directly downstream of the ALU and the array multiplier.
- Normal ALU results are written on the clock edge.
- Multiplier results arrive late because of the long combinational path. They pass through a one-entry pending-write slot and commit one edge later.
- Reads forward from the pending slot, so the datapath never sees stale data.

Parameters:
- WIDTH, 8, data width of each register and of all data ports.
- ADDR_W, 3, register address width; depth = 2**ADDR_W.
- READ_DELAY, 2, simulation delay (time units) on OUT1/OUT2.
- WRITE_DELAY, 1, simulation delay (time units) on register and slot updates.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset; sampled on posedge CLK.
- IN  input  WIDTH  ALU write-back data.
- INADDRESS  input  ADDR_W  destination register for IN.
- WRITE  input  1  ALU write enable.
- MULT_IN  input  WIDTH  multiplier RESULT (low byte, signed).
- MULT_ADDRESS  input  ADDR_W  destination register for MULT_IN.
- MULT_WRITE  input  1  multiplier write enable.
- OUT1ADDRESS  input  ADDR_W  read port 1 address.
- OUT2ADDRESS  input  ADDR_W  read port 2 address.
- OUT1  output  WIDTH  read port 1 data.
- OUT2  output  WIDTH  read port 2 data.
- PENDING  output  1  pending slot holds an uncommitted multiplier result.
- PENDING_ADDRESS  output  ADDR_W  destination register of the pending slot.
- WR_CONFLICT  output  1  one-cycle flag: WRITE and MULT_WRITE were both asserted.

Behaviour:
- Reset:
  - RESET=1 at posedge clears REG[0..7], the pending slot (PENDING=0, PENDING_ADDRESS=0, data=0) and WR_CONFLICT=0.
  - Reset overrides every write at that edge, including a pending commit. A mid-operation pending write is lost.
- Normal write: at posedge with RESET=0, WRITE=1, MULT_WRITE=0, REG[INADDRESS] <= IN after WRITE_DELAY.
- Pending-slot state machine, states EMPTY and FULL (PENDING reflects the state):
  - EMPTY + MULT_WRITE=1 -> FULL. Slot captures MULT_IN and MULT_ADDRESS.
  - FULL + MULT_WRITE=0 -> EMPTY. REG[slot addr] <= slot data at this edge.
  - FULL + MULT_WRITE=1 -> FULL. Old slot commits to REG and the new result is captured, back-to-back at the same edge.
- Commit vs ALU write at the same edge: if the slot commits while WRITE=1 targets the same address, the ALU write wins (it is younger) and the commit is discarded. A different address means both writes occur.
- Conflict: WRITE=1 and MULT_WRITE=1 at the same edge is illegal.
  - MULT_WRITE takes priority and the ALU write is dropped.
  - WR_CONFLICT=1 for exactly the following cycle, then returns to 0.
- Reads: combinational, after READ_DELAY.
  - OUTn = slot data if PENDING=1 and PENDING_ADDRESS == OUTnADDRESS; otherwise REG[OUTnADDRESS].
  - No forwarding from IN or MULT_IN (same-cycle write data is not visible until after the edge).
- Both read ports are independent. Reading the same address on both ports returns identical data.
- All registers are writable; there is no hardwired-zero register.
- Data is stored as raw bits and never sign-extended or modified.

Test Plan:
- Reset:
  - Stimulus: write 0x5A to R3, then assert RESET=1 for one edge.
  - Required: OUT1 (addr 3) = 0x00 and PENDING=0 after reset; WR_CONFLICT=0.
- ALU write/read:
  - Stimulus: WRITE R1=0x11 and R2=0xF0 on consecutive edges; read OUT1=R1, OUT2=R2.
  - Required: 0x11 and 0xF0 appear 2 time units after address change.
- Multiplier forwarding:
  - Stimulus: MULT_WRITE R4=0xC8 (-56); read R4 in the next cycle.
  - Required: PENDING=1, PENDING_ADDRESS=4, OUT1=0xC8. After the following idle edge, PENDING=0 and OUT1=0xC8 from REG.
- Back-to-back multiplies:
  - Stimulus: MULT_WRITE R5=0x06, then next edge MULT_WRITE R6=0x0F.
  - Required: after the second edge R5=0x06 is committed, slot holds R6=0x0F, PENDING stays 1.
- Commit collision:
  - Stimulus: MULT_WRITE R2=0x33; at the next edge WRITE R2=0x44.
  - Required: R2=0x44, PENDING=0, and 0x33 never visible after that edge.
- Conflict and reset-while-pending:
  - Conflict stimulus: WRITE R7=0xAA together with MULT_WRITE R0=0x01. Required: R7 unchanged, slot holds R0=0x01, WR_CONFLICT=1 for exactly one cycle.
  - Reset-while-pending stimulus: assert RESET while PENDING=1. Required: R0 stays 0x00 and PENDING=0.
